// File: rtl/tribus_pkg.sv
// Shared types and default parameters for the tristate bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tribus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int DEAD_CYC_DEF = 1;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/tribus_arbiter_if.sv
// Request/enable bundle between requesters and the tristate bus arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until they see their oe bit; the arbiter may cut oe at any time.
// Signals: req (per-requester level request), oe (one-hot-or-zero driver enable),
//          owner (current/last owner index), busy (arbiter not idle), preempt (forced-release pulse).
interface tribus_arbiter_if import tribus_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF
) ();
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] oe;
    logic [IDX_W-1:0] owner;
    logic             busy;
    logic             preempt;

    // master: the requester side; slave: the arbiter
    modport master (output req, input oe, owner, busy, preempt);
    modport slave  (input req, output oe, owner, busy, preempt);
endinterface

// File: rtl/tribus_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo N_REQ.
// Latency: combinational.
// Backpressure: none; valid is low when no request is set.
// Ports: req (request vector), ptr (search start index), winner (picked index), valid (any request).
module rr_pick import tribus_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // one extra bit so ptr + i cannot overflow before the wrap
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Tristate bus arbiter: round-robin grant, MAX_HOLD drive limit, DEAD_CYC float between owners.
// Latency: oe rises 1 cycle after req is first sampled in IDLE; drop of req ends the grant 1 cycle later.
// Backpressure: owners are forced off after MAX_HOLD cycles (preempt pulse); others wait, requests held level.
// Ports: clk, rst_n (async active-low); bus.slave carries req in, oe/owner/busy/preempt out (all registered).
module tribus_arbiter import tribus_pkg::*; #(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    tribus_arbiter_if.slave    bus
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic [3:0]       turn_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [IDX_W-1:0] next_ptr;
    logic             owner_req;
    logic             hold_done;
    logic             turn_done;
    logic             grant_now;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    assign next_ptr  = (bus.owner == IDX_W'(N_REQ-1)) ? '0 : bus.owner + 1'b1;
    assign owner_req = bus.req[bus.owner];
    assign hold_done = (hold_cnt == 8'(MAX_HOLD));
    assign turn_done = (turn_cnt == 4'(DEAD_CYC));
    // a new owner is taken from IDLE, or straight out of the last TURN cycle
    assign grant_now = pick_vld && ((state == IDLE) || ((state == TURN) && turn_done));

    // reset clears oe asynchronously, so the bus is released mid-cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.oe      <= '0;
            bus.owner   <= '0;
            bus.busy    <= 1'b0;
            bus.preempt <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
            turn_cnt    <= '0;
        end else begin
            bus.preempt <= 1'b0;
            if (grant_now) begin
                state     <= DRIVE;
                bus.owner <= pick_idx;
                bus.oe    <= N_REQ'(1) << pick_idx;
                bus.busy  <= 1'b1;
                hold_cnt  <= 8'd1;
                turn_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.oe   <= '0;
                        bus.busy <= 1'b0;
                    end
                    DRIVE: begin
                        if (!owner_req || hold_done) begin
                            state       <= TURN;
                            bus.oe      <= '0;
                            // a release coinciding with expiry is a normal release
                            bus.preempt <= owner_req && hold_done;
                            ptr         <= next_ptr;
                            hold_cnt    <= '0;
                            turn_cnt    <= 4'd1;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    TURN: begin
                        if (turn_done) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            turn_cnt <= '0;
                        end else begin
                            turn_cnt <= turn_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.oe   <= '0;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter with four tristate drivers on one shared line.
// Latency: n/a.
// Backpressure: n/a.
module tb_tribus_arbiter;
    import tribus_pkg::*;

    logic clk;
    logic rst_n;

    tribus_arbiter_if #(.N_REQ(4)) bus_if ();

    tribus_arbiter #(.N_REQ(4), .DEAD_CYC(1), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [3:0] drv_dat;
    wire        bus_line;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_drv
        bufif1 u_buf (bus_line, drv_dat[g], bus_if.oe[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] oe;
        logic       busy;
        logic       preempt;
        logic [1:0] owner;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] oe, input logic busy, input logic pre, input logic [1:0] own);
        exp_t e;
        e.oe = oe; e.busy = busy; e.preempt = pre; e.owner = own;
        sb.push_back(e);
    endtask

    // advance one clock, then compare outputs against the oldest expectation
    task automatic tick_chk(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_oe"},      32'(bus_if.oe),      32'(e.oe));
            chk({tag, "_busy"},    32'(bus_if.busy),    32'(e.busy));
            chk({tag, "_preempt"}, 32'(bus_if.preempt), 32'(e.preempt));
            chk({tag, "_owner"},   32'(bus_if.owner),   32'(e.owner));
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus_if.req = 4'b0000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // continuous invariants: single driver, no X on the line, a gap between owners
    logic [3:0] prev_oe = 4'b0000;
    always @(negedge clk) begin
        chk("onehot", 32'($countones(bus_if.oe) <= 1), 32'd1);
        if (rst_n && bus_if.oe != 4'b0000) begin
            chk("bus_x", 32'($isunknown(bus_line)), 32'd0);
        end
        chk("oe_gap", 32'(prev_oe == 4'b0000 || bus_if.oe == 4'b0000 || bus_if.oe == prev_oe), 32'd1);
        prev_oe = bus_if.oe;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n_pre;
        drv_dat    = 4'b1010;
        rst_n      = 1'b0;
        bus_if.req = 4'b0000;

        // reset state
        @(posedge clk);
        #1;
        chk("rst_oe",      32'(bus_if.oe),      32'd0);
        chk("rst_busy",    32'(bus_if.busy),    32'd0);
        chk("rst_preempt", 32'(bus_if.preempt), 32'd0);
        chk("rst_owner",   32'(bus_if.owner),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single requester, 3-cycle request
        bus_if.req = 4'b0100;
        push(4'b0100, 1, 0, 2);
        push(4'b0100, 1, 0, 2);
        push(4'b0100, 1, 0, 2);
        push(4'b0000, 1, 0, 2);
        push(4'b0000, 0, 0, 2);
        tick_chk("single_c1");
        tick_chk("single_c2");
        tick_chk("single_c3");
        bus_if.req = 4'b0000;
        tick_chk("single_turn");
        tick_chk("single_idle");
        chk("single_sb_empty", 32'(sb.size()), 32'd0);

        // all requesting: rotation with forced releases
        do_reset();
        bus_if.req = 4'b1111;
        for (int gi = 0; gi < 5; gi++) begin
            for (int c = 0; c < 8; c++) begin
                push(4'(1 << (gi % 4)), 1, 0, 2'(gi % 4));
            end
            if (gi < 4) begin
                push(4'b0000, 1, 1, 2'(gi % 4));
            end
        end
        n_pre = 0;
        for (int k = 0; k < 44; k++) begin
            tick_chk("rot");
            if (bus_if.preempt === 1'b1) n_pre++;
        end
        chk("rot_preempt_count", 32'(n_pre), 32'd4);
        chk("rot_sb_empty", 32'(sb.size()), 32'd0);

        // owner releases early, next requester follows after one float cycle
        do_reset();
        bus_if.req = 4'b0011;
        push(4'b0001, 1, 0, 0);
        push(4'b0001, 1, 0, 0);
        push(4'b0000, 1, 0, 0);
        push(4'b0010, 1, 0, 1);
        push(4'b0010, 1, 0, 1);
        push(4'b0000, 1, 0, 1);
        push(4'b0000, 0, 0, 1);
        tick_chk("rel_c1");
        tick_chk("rel_c2");
        bus_if.req = 4'b0010;
        tick_chk("rel_turn");
        tick_chk("rel_next1");
        tick_chk("rel_next2");
        bus_if.req = 4'b0000;
        tick_chk("rel_turn2");
        tick_chk("rel_idle");

        // asynchronous reset in the middle of a grant
        do_reset();
        bus_if.req = 4'b0100;
        push(4'b0100, 1, 0, 2);
        tick_chk("arst_grant");
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_oe",    32'(bus_if.oe),    32'd0);
        chk("arst_busy",  32'(bus_if.busy),  32'd0);
        chk("arst_owner", 32'(bus_if.owner), 32'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus_if.req = 4'b1010;
        push(4'b0010, 1, 0, 1);
        push(4'b0010, 1, 0, 1);
        tick_chk("arst_after1");
        tick_chk("arst_after2");

        // release on the very cycle the hold limit is reached
        do_reset();
        bus_if.req = 4'b0100;
        for (int c = 0; c < 8; c++) push(4'b0100, 1, 0, 2);
        push(4'b0000, 1, 0, 2);
        push(4'b0000, 0, 0, 2);
        for (int c = 0; c < 8; c++) tick_chk("edge_drive");
        bus_if.req = 4'b0000;
        tick_chk("edge_turn");
        tick_chk("edge_idle");
        chk("edge_sb_empty", 32'(sb.size()), 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
